// File: rtl/vblank_task_scheduler_pkg.sv
// Types and widths for the vblank task scheduler.
package vblank_task_scheduler_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_GAP  = 2'd2
  } sched_state_t;

  localparam int WD_W  = 10;
  localparam int DIV_W = 4;
  localparam int FC_W  = 8;
endpackage

// File: rtl/video_timing_pkg.sv
// Raster geometry shared by the video timing generator and the blocks that
// key off its sx/sy counters.
package video_timing_pkg;
  localparam int HA_END = 639;
  localparam int VA_END = 479;
  localparam int LINE   = 799;
  localparam int SCREEN = 524;
endpackage

// File: rtl/vblank_task_scheduler_if.sv
// Request/acknowledge bundle between the scheduler and the game-logic units.
interface vblank_task_scheduler_if #(
  parameter int NUM_TASKS = 4
);
  logic [NUM_TASKS-1:0] task_req;
  logic [NUM_TASKS-1:0] task_ack;

  modport master (output task_req, input task_ack);
  modport slave  (input task_req, output task_ack);
endinterface

// File: rtl/sched_watchdog.sv
// Loadable per-task timeout counter; expire flags the cycle the count equals TIMEOUT.
module sched_watchdog #(
  parameter int WIDTH   = 10,
  parameter int TIMEOUT = 1023
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clear,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_inc,
  output logic             o_expire
);
  logic [WIDTH-1:0] r_count;

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_inc) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_expire = (r_count == WIDTH'(TIMEOUT));
endmodule

// File: rtl/vblank_task_scheduler.sv
// Issues one req/ack handshake per game-logic task during vertical blanking,
// with a per-task timeout and an end-of-frame deadline abort.
module vblank_task_scheduler
  import vblank_task_scheduler_pkg::*;
#(
  parameter int NUM_TASKS = 4,
  parameter int VA_END    = video_timing_pkg::VA_END,
  parameter int LINE      = video_timing_pkg::LINE,
  parameter int SCREEN    = video_timing_pkg::SCREEN,
  parameter int TIMEOUT   = 1023,
  parameter int FRAME_DIV = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [9:0]              sx,
  input  logic [9:0]              sy,
  input  logic                    enable,
  vblank_task_scheduler_if.master task_bus,
  output logic                    busy,
  output logic                    frame_tick,
  output logic [FC_W-1:0]         frame_count,
  output logic                    overrun,
  output logic                    timeout_err,
  input  logic                    err_clear
);
  localparam int IDX_W = (NUM_TASKS > 1) ? $clog2(NUM_TASKS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TASKS - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FRAME_DIV - 1);

  sched_state_t         r_state;
  logic [IDX_W-1:0]     r_idx;
  logic [DIV_W-1:0]     r_div;
  logic [NUM_TASKS-1:0] r_task_req;
  logic                 r_busy;
  logic                 r_tick;
  logic [FC_W-1:0]      r_frame_count;
  logic                 r_overrun;
  logic                 r_timeout_err;

  logic             w_vstart;
  logic             w_deadline;
  logic             w_start;
  logic             w_abort;
  logic             w_ack;
  logic             w_expire;
  logic [IDX_W-1:0] w_next_idx;

  assign w_vstart   = (sx == 10'd0) && (sy == 10'(VA_END + 1));
  assign w_deadline = (sx == 10'(LINE)) && (sy == 10'(SCREEN));
  assign w_start    = w_vstart && enable && (r_div == '0) && (r_state == ST_IDLE);
  assign w_abort    = w_deadline && (r_state != ST_IDLE);
  assign w_ack      = task_bus.task_ack[r_idx];
  assign w_next_idx = r_idx + IDX_W'(1);

  sched_watchdog #(
    .WIDTH   (WD_W),
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clear    ((r_state == ST_GAP) || w_abort),
    .i_load     (w_start),
    .i_load_val ('0),
    .i_inc      (r_state == ST_REQ),
    .o_expire   (w_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_idx         <= '0;
      r_div         <= '0;
      r_task_req    <= '0;
      r_busy        <= 1'b0;
      r_tick        <= 1'b0;
      r_frame_count <= '0;
      r_overrun     <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      // The divider counts every enabled vstart, even ones that land while busy.
      if (w_vstart && enable) begin
        r_div <= (r_div == DIV_LAST) ? '0 : r_div + DIV_W'(1);
      end
      if (err_clear) begin
        r_overrun     <= 1'b0;
        r_timeout_err <= 1'b0;
      end

      if (w_abort) begin
        r_state    <= ST_IDLE;
        r_task_req <= '0;
        r_busy     <= 1'b0;
        r_idx      <= '0;
        r_overrun  <= 1'b1;
      end else begin
        unique case (r_state)
          ST_IDLE: begin
            if (w_start) begin
              r_state       <= ST_REQ;
              r_idx         <= '0;
              r_task_req    <= NUM_TASKS'(1);
              r_busy        <= 1'b1;
              r_tick        <= 1'b1;
              r_frame_count <= r_frame_count + FC_W'(1);
            end
          end
          ST_REQ: begin
            // Ack wins over a simultaneous expiry; a timed-out task is simply skipped.
            if (w_ack || w_expire) begin
              r_task_req <= '0;
              if (!w_ack) r_timeout_err <= 1'b1;
              if (r_idx == LAST_IDX) begin
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
                r_idx   <= '0;
              end else begin
                r_state <= ST_GAP;
              end
            end
          end
          ST_GAP: begin
            r_state    <= ST_REQ;
            r_idx      <= w_next_idx;
            r_task_req <= NUM_TASKS'(1) << w_next_idx;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign task_bus.task_req = r_task_req;
  assign busy              = r_busy;
  assign frame_tick        = r_tick;
  assign frame_count       = r_frame_count;
  assign overrun           = r_overrun;
  assign timeout_err       = r_timeout_err;
endmodule
